// File: rtl/miter_pkg.sv
// Shared types and helpers for the gold-versus-gate comparison monitor.
package miter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FAILED, HALT} mon_state_e;

   // Widest counter the saturating helper supports.
   localparam int SAT_MAX_W = 64;

   function automatic int ch_idx_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                    input int                   w);
      logic [SAT_MAX_W-1:0] lim;
      lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
      return (val == lim) ? val : val + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/miter_lane_cmp.sv
// One channel of the masked compare: a bit fails when it is not don't-care and gold differs from gate.
module miter_lane_cmp #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] gold,
   input  logic [WIDTH-1:0] gate,
   input  logic [WIDTH-1:0] dc_mask,
   output logic             mismatch
);

   assign mismatch = |((gold ^ gate) & ~dc_mask);

endmodule

// File: rtl/miter_cmp_monitor.sv
// Clocked gold-versus-gate comparison monitor: per-channel masked compare with sticky failure,
// saturating counters, first-failure capture and optional stop-on-fail.
module miter_cmp_monitor
   import miter_pkg::*;
#(
   parameter int WIDTH        = 1,
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 16,
   parameter int PIPE         = 0,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          clear,
   input  logic                          valid,
   input  logic [CHANNELS*WIDTH-1:0]     gold,
   input  logic [CHANNELS*WIDTH-1:0]     gate,
   input  logic [CHANNELS*WIDTH-1:0]     dc_mask,
   output logic [CHANNELS-1:0]           mismatch,
   output logic                          fail,
   output logic [CNT_W-1:0]              err_cnt,
   output logic [CNT_W-1:0]              cyc_cnt,
   output logic [ch_idx_w(CHANNELS)-1:0] first_ch,
   output logic [CNT_W-1:0]              first_idx,
   output logic                          halted
);

   localparam int N    = CHANNELS * WIDTH;
   localparam int CH_W = ch_idx_w(CHANNELS);

   mon_state_e          state_q, state_d;
   logic [CHANNELS-1:0] mismatch_q, mismatch_d;
   logic                fail_q, fail_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0]    first_idx_q, first_idx_d;
   logic [CH_W-1:0]     first_ch_q, first_ch_d;

   logic                take;
   logic                cmp_vld;
   logic [N-1:0]        cmp_gold, cmp_gate, cmp_mask;
   logic [CHANNELS-1:0] lane_mm;
   logic [CH_W-1:0]     low_ch;

   // Qualifiers are judged at the sampling edge, ahead of the optional input register.
   assign take = valid & en & (state_q != HALT);

   if (PIPE != 0) begin : g_pipe
      logic         pipe_vld_q, pipe_vld_d;
      logic [N-1:0] pipe_gold_q, pipe_gold_d;
      logic [N-1:0] pipe_gate_q, pipe_gate_d;
      logic [N-1:0] pipe_mask_q, pipe_mask_d;

      always_comb begin
         pipe_vld_d  = take & ~clear;
         pipe_gold_d = take ? gold    : pipe_gold_q;
         pipe_gate_d = take ? gate    : pipe_gate_q;
         pipe_mask_d = take ? dc_mask : pipe_mask_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_gold_q <= '0;
            pipe_gate_q <= '0;
            pipe_mask_q <= '0;
         end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_gold_q <= pipe_gold_d;
            pipe_gate_q <= pipe_gate_d;
            pipe_mask_q <= pipe_mask_d;
         end
      end

      // An in-flight sample completes even with en low, but is dropped once HALT is reached.
      assign cmp_vld  = pipe_vld_q & (state_q != HALT);
      assign cmp_gold = pipe_gold_q;
      assign cmp_gate = pipe_gate_q;
      assign cmp_mask = pipe_mask_q;
   end else begin : g_direct
      assign cmp_vld  = take;
      assign cmp_gold = gold;
      assign cmp_gate = gate;
      assign cmp_mask = dc_mask;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      miter_lane_cmp #(.WIDTH(WIDTH)) u_lane (
         .gold     (cmp_gold[c*WIDTH +: WIDTH]),
         .gate     (cmp_gate[c*WIDTH +: WIDTH]),
         .dc_mask  (cmp_mask[c*WIDTH +: WIDTH]),
         .mismatch (lane_mm[c])
      );
   end

   always_comb begin
      low_ch = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (lane_mm[c]) low_ch = CH_W'(c);
      end
   end

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      mismatch_d  = mismatch_q;
      fail_d      = fail_q;
      err_cnt_d   = err_cnt_q;
      cyc_cnt_d   = cyc_cnt_q;
      first_idx_d = first_idx_q;
      first_ch_d  = first_ch_q;
      if (clear) begin
         state_d     = IDLE;
         mismatch_d  = '0;
         fail_d      = 1'b0;
         err_cnt_d   = '0;
         cyc_cnt_d   = '0;
         first_idx_d = '0;
         first_ch_d  = '0;
      end else if (cmp_vld) begin
         mismatch_d = lane_mm;
         cyc_cnt_d  = CNT_W'(sat_inc(SAT_MAX_W'(cyc_cnt_q), CNT_W));
         if (|lane_mm) begin
            err_cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(err_cnt_q), CNT_W));
            if (state_q == IDLE || state_q == RUN) begin
               fail_d      = 1'b1;
               first_ch_d  = low_ch;
               first_idx_d = cyc_cnt_q;
               state_d     = (STOP_ON_FAIL != 0) ? HALT : FAILED;
            end
         end else if (state_q == IDLE) begin
            state_d = RUN;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mismatch_q  <= '0;
         fail_q      <= 1'b0;
         err_cnt_q   <= '0;
         cyc_cnt_q   <= '0;
         first_idx_q <= '0;
         first_ch_q  <= '0;
      end else begin
         state_q     <= state_d;
         mismatch_q  <= mismatch_d;
         fail_q      <= fail_d;
         err_cnt_q   <= err_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         first_idx_q <= first_idx_d;
         first_ch_q  <= first_ch_d;
      end
   end

   assign mismatch  = mismatch_q;
   assign fail      = fail_q;
   assign err_cnt   = err_cnt_q;
   assign cyc_cnt   = cyc_cnt_q;
   assign first_idx = first_idx_q;
   assign first_ch  = first_ch_q;
   assign halted    = (state_q == HALT);

endmodule

// File: doc/miter_cmp_monitor.md
# miter_cmp_monitor

Parametrised, clocked gold-versus-gate comparison monitor for the aes_cipher_top equivalence flow. It generalises the single-bit, single-partition output comparison to CHANNELS partitions of WIDTH bits each. Gold don't-care bits are expressed as a synthesizable mask. The block adds sticky failure tracking, a saturating error count, first-failure capture and an optional stop-on-fail mode. It sits beside the gold and gate netlist instances in simulation and FPGA-prototype benches.

## Interface
- WIDTH, 1 — bits per channel (≥1)
- CHANNELS, 4 — number of compared partitions (≥1)
- CNT_W, 16 — width of error and cycle counters
- PIPE, 0 — 1 adds an input register stage
- STOP_ON_FAIL, 0 — 1 halts comparison after first failure

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  comparison enable
- clear  in  1  synchronous clear of all status and counters
- valid  in  1  gold/gate/dc_mask are sampled this cycle
- gold  in  CHANNELS*WIDTH  gold outputs, channel c at [c*WIDTH +: WIDTH]
- gate  in  CHANNELS*WIDTH  gate outputs, same packing
- dc_mask  in  CHANNELS*WIDTH  1 = gold bit is don't-care (never mismatches)
- mismatch  out  CHANNELS  per-channel mismatch for the current compared sample
- fail  out  1  sticky: any mismatch since reset/clear
- err_cnt  out  CNT_W  saturating count of failing samples
- cyc_cnt  out  CNT_W  saturating count of compared samples
- first_ch  out  $clog2(CHANNELS) (min 1)  lowest failing channel of first failure
- first_idx  out  CNT_W  cyc_cnt value at first failure
- halted  out  1  high in HALT state

## Operation
- Per-bit failure: dc_mask=0 and gold≠gate. A channel mismatches if any of its bits fails.
- A sample is compared when valid=1, en=1 and state≠HALT. These qualifiers are taken at the sampling edge, i.e. before PIPE.
- States:
  - IDLE: reached from reset or clear. Moves to RUN on the first compared sample.
  - RUN → FAILED on the first sample with any mismatch.
  - FAILED → HALT on the same edge if STOP_ON_FAIL=1; otherwise stays in FAILED.
  - HALT is left only by clear or rst.
- cyc_cnt increments by 1 per compared sample and saturates at all-ones.
- err_cnt increments by 1 per failing sample, not per channel, and saturates at all-ones.
- On the first failure: fail←1, first_ch←lowest-index mismatching channel, first_idx←cyc_cnt before the increment. These are not updated by later failures.
- mismatch updates every compared sample and holds its value otherwise. It is zero in IDLE and after clear.
- clear has priority over every same-cycle event. It zeroes all outputs, flushes the PIPE stage and returns to IDLE; the sample in that cycle is discarded.
- en=0 freezes all state; an in-flight PIPE sample still completes.

## Timing
- Reset value of every output is 0, and state is IDLE.
- Latency from sampling edge to outputs: 1 cycle (PIPE=0) or 2 cycles (PIPE=1). mismatch, fail, counters and captures all update on the same edge.
- Back-to-back valid is supported at full rate with no stalls.
- In HALT, samples in the PIPE stage that were accepted before the fail edge are dropped.
- rst mid-operation clears immediately, asynchronously, including the pipeline register.
- Counter saturation: at all-ones, further events leave the value unchanged; fail is still set correctly.

## Structure
- Package miter_pkg:
  - state enum mon_state_e {IDLE, RUN, FAILED, HALT}
  - localparam helper for first_ch width, max(1, $clog2(CHANNELS))
  - saturating-increment function
- Sub-module miter_lane_cmp: WIDTH-bit masked compare per channel, purely combinational, instantiated CHANNELS times by generate.
- Top-level block holds the optional PIPE register, FSM, counters, priority encoder and capture registers.

## Test plan
- CHANNELS=4, WIDTH=8, gold=gate for 10 samples → mismatch=0, fail=0, cyc_cnt=10, err_cnt=0.
- Sample 5: gate ch2 and ch1 differ from gold → fail=1, first_ch=1, first_idx=4, err_cnt=1, mismatch=4'b0110 one cycle after the sample (two with PIPE=1).
- dc_mask covers every differing bit → no failure, cyc_cnt still advances.
- STOP_ON_FAIL=1: failure at sample 3 then 5 more failing samples → halted=1, err_cnt=1, cyc_cnt=3. Then clear → all outputs 0, state IDLE.
- CNT_W=4: 20 failing samples → err_cnt=15, cyc_cnt=15, first_idx=0.
- clear and a failing sample in the same cycle → outputs remain 0. Separately, rst asserted mid-RUN with PIPE=1 → all outputs 0 immediately, and no stale result after rst deasserts.
